// File: rtl/fp_mul_arbiter_if.sv
// Bundle between requesters, the shared multiplier and the response consumer.
// The slave modport is the arbiter's view; the master modport is the surrounding datapath's view.
interface fp_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [31:0]           mul_a;
  logic [31:0]           mul_b;
  logic [31:0]           mul_result;
  logic                  mul_overflow;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_result;
  logic                  rsp_overflow;
  logic [ID_W-1:0]       rsp_id;
  logic [15:0]           op_count;

  modport slave (
    input  req_valid, req_a, req_b, mul_result, mul_overflow, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_result, rsp_overflow, rsp_id, op_count
  );

  modport master (
    output req_valid, req_a, req_b, mul_result, mul_overflow, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_result, rsp_overflow, rsp_id, op_count
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin share of one combinational FP multiplier; 2 cycles accept-to-response, one op per 3 cycles.
// A stalled response holds RESP indefinitely and no request is accepted until it drains.
module fp_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  fp_mul_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_id;
  logic [ID_W-1:0]     w_grant;
  logic                w_found;
  logic                w_hs;
  logic                w_rsp_valid;
  logic [NUM_REQ-1:0]  w_ready;
  logic [31:0]         r_mul_a;
  logic [31:0]         r_mul_b;
  logic [31:0]         r_rsp_result;
  logic                r_rsp_overflow;
  logic [15:0]         r_op_count;

  function automatic logic [ID_W-1:0] wrap_idx(input int i);
    return ID_W'(i % NUM_REQ);
  endfunction

  // First valid requester at or after ptr, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && bus.req_valid[wrap_idx(int'(r_ptr) + k)]) begin
        w_found = 1'b1;
        w_grant = wrap_idx(int'(r_ptr) + k);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hs        = 1'b0;
    w_ready     = '0;
    w_rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found && !i_rst) begin
          w_hs             = 1'b1;
          w_ready[w_grant] = 1'b1;
          w_state_nxt      = S_EXEC;
        end
      end
      S_EXEC: w_state_nxt = S_RESP;
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr          <= '0;
      r_id           <= '0;
      r_mul_a        <= '0;
      r_mul_b        <= '0;
      r_rsp_result   <= '0;
      r_rsp_overflow <= 1'b0;
      r_op_count     <= '0;
    end else begin
      if (w_hs) begin
        r_mul_a <= bus.req_a[int'(w_grant)*32 +: 32];
        r_mul_b <= bus.req_b[int'(w_grant)*32 +: 32];
        r_id    <= w_grant;
        r_ptr   <= wrap_idx(int'(w_grant) + 1);
      end
      // Multiplier is combinational from the operand registers, so EXEC's result is final.
      if (r_state == S_EXEC) begin
        r_rsp_result   <= bus.mul_result;
        r_rsp_overflow <= bus.mul_overflow;
      end
      if (r_state == S_RESP && bus.rsp_ready) r_op_count <= r_op_count + 16'd1;
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.mul_a        = r_mul_a;
  assign bus.mul_b        = r_mul_b;
  assign bus.rsp_valid    = w_rsp_valid;
  assign bus.rsp_result   = r_rsp_result;
  assign bus.rsp_overflow = r_rsp_overflow;
  assign bus.rsp_id       = r_id;
  assign bus.op_count     = r_op_count;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter with a truncating FP32 multiplier stub standing in for the external unit.
module tb_fp_mul_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  fp_mul_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  fp_mul_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Returns {overflow, product}; normal operands only, zero/subnormal flush, inf saturates with overflow.
  function automatic logic [32:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, e;
    logic [47:0] p;
    logic [22:0] m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) return {1'b1, s, 8'hFF, 23'h0};
    if (ea == 0 || eb == 0) return {1'b0, s, 31'h0};
    p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    e = ea + eb - 127;
    if (p[47]) begin m = p[46:24]; e++; end
    else m = p[45:23];
    if (e >= 255) return {1'b1, s, 8'hFF, 23'h0};
    if (e <= 0) return {1'b0, s, 31'h0};
    return {1'b0, s, e[7:0], m};
  endfunction

  assign {bus.mul_overflow, bus.mul_result} = fmul(bus.mul_a, bus.mul_b);

  function automatic logic [31:0] rnd_fp();
    logic [31:0] r;
    logic [7:0]  e;
    r = $urandom;
    if ($urandom_range(0, 9) == 0) e = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
    else e = 8'($urandom_range(64, 190));
    return {r[31], e, r[22:0]};
  endfunction

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    to_drive();
    to_drive();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'b0110;
    @(negedge clk);
    n_chk++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_held: got %b want 0000", bus.req_ready); end
    n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    rst = 1'b0;
    #1;
    n_chk++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL reset_ready_release: got %b want 0010", bus.req_ready); end
    n_chk++; if (bus.mul_a !== 32'h0 || bus.mul_b !== 32'h0) begin n_fail++; $display("FAIL reset_mul: got %h %h want 0 0", bus.mul_a, bus.mul_b); end
    n_chk++; if (bus.rsp_result !== 32'h0 || bus.rsp_overflow !== 1'b0 || bus.rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL reset_rsp: got %h %b %0d want 0 0 0", bus.rsp_result, bus.rsp_overflow, bus.rsp_id); end
    n_chk++; if (bus.op_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.op_count); end
    bus.req_valid = '0;
    to_drive();
  endtask

  task automatic test_single_op();
    do_reset();
    set_op(1, 32'h40800000, 32'h40A00000);
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_ready: got %b want 0010", bus.req_ready); end
    to_drive();
    bus.req_valid = '0;
    @(negedge clk);
    n_chk++; if (bus.mul_a !== 32'h40800000 || bus.mul_b !== 32'h40A00000) begin
      n_fail++; $display("FAIL single_operands: got %h %h want 40800000 40a00000", bus.mul_a, bus.mul_b); end
    n_chk++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL single_exec: got vld %b rdy %b want 0 0000", bus.rsp_valid, bus.req_ready); end
    to_drive();
    @(negedge clk);
    n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'h41A00000 || bus.rsp_overflow !== 1'b0 || bus.rsp_id !== 2'd1) begin
      n_fail++; $display("FAIL single_rsp: got %b %h %b %0d want 1 41a00000 0 1", bus.rsp_valid, bus.rsp_result, bus.rsp_overflow, bus.rsp_id); end
    to_drive();
    @(negedge clk);
    n_chk++; if (bus.op_count !== 16'd1 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_done: got cnt %0d vld %b want 1 0", bus.op_count, bus.rsp_valid); end
  endtask

  task automatic test_contention();
    logic [31:0] oa[4], ob[4];
    logic [32:0] ex[4];
    logic [3:0]  want;
    int          k;
    do_reset();
    oa[0] = 32'h42480000; ob[0] = 32'hC2A00000; ex[0] = {1'b0, 32'hC57A0000};
    oa[1] = 32'hC1200000; ob[1] = 32'hC1A00000; ex[1] = {1'b0, 32'h43480000};
    for (int i = 2; i < 4; i++) begin oa[i] = rnd_fp(); ob[i] = rnd_fp(); ex[i] = fmul(oa[i], ob[i]); end
    for (int i = 0; i < 4; i++) set_op(i, oa[i], ob[i]);
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      k = cyc / 3;
      want = (cyc % 3 == 0) ? (4'b0001 << k) : 4'b0000;
      n_chk++; if (bus.req_ready !== want) begin n_fail++; $display("FAIL contend_ready c%0d: got %b want %b", cyc, bus.req_ready, want); end
      n_chk++; if (bus.rsp_valid !== (cyc % 3 == 2)) begin n_fail++; $display("FAIL contend_vld c%0d: got %b", cyc, bus.rsp_valid); end
      if (cyc % 3 == 2) begin
        n_chk++; if (bus.rsp_id !== 2'(k) || {bus.rsp_overflow, bus.rsp_result} !== ex[k]) begin
          n_fail++; $display("FAIL contend_rsp c%0d: got id %0d %b %h want id %0d %h", cyc, bus.rsp_id, bus.rsp_overflow, bus.rsp_result, k, ex[k]); end
      end
      to_drive();
      if (cyc % 3 == 0) bus.req_valid[k] = 1'b0;
    end
  endtask

  task automatic test_fairness();
    logic [3:0] want;
    int         k;
    do_reset();
    set_op(0, rnd_fp(), rnd_fp());
    set_op(2, rnd_fp(), rnd_fp());
    bus.req_valid = 4'b0101;
    bus.rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      k = cyc / 3;
      want = (cyc % 3 != 0) ? 4'b0000 : ((k % 2 == 0) ? 4'b0001 : 4'b0100);
      n_chk++; if (bus.req_ready !== want) begin n_fail++; $display("FAIL fair_ready c%0d: got %b want %b", cyc, bus.req_ready, want); end
      if (cyc % 3 == 2) begin
        n_chk++; if (bus.rsp_id !== ((k % 2 == 0) ? 2'd0 : 2'd2)) begin n_fail++; $display("FAIL fair_id c%0d: got %0d", cyc, bus.rsp_id); end
      end
      to_drive();
      if (cyc % 3 == 0) set_op((k % 2 == 0) ? 0 : 2, rnd_fp(), rnd_fp());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    logic [32:0] ex;
    do_reset();
    a = rnd_fp(); b = rnd_fp(); ex = fmul(a, b);
    set_op(0, a, b);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_grant: got %b want 0001", bus.req_ready); end
    to_drive();
    bus.req_valid = 4'b0010;
    set_op(1, rnd_fp(), rnd_fp());
    to_drive();
    for (int cyc = 2; cyc < 8; cyc++) begin
      @(negedge clk);
      n_chk++; if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 4'b0000 || bus.rsp_id !== 2'd0 || {bus.rsp_overflow, bus.rsp_result} !== ex) begin
        n_fail++; $display("FAIL bp_hold c%0d: got vld %b rdy %b id %0d %b %h want 1 0000 0 %h", cyc, bus.rsp_valid, bus.req_ready, bus.rsp_id, bus.rsp_overflow, bus.rsp_result, ex); end
      to_drive();
      bus.rsp_ready = (cyc == 6);
    end
    @(negedge clk);
    n_chk++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0010 || bus.op_count !== 16'd1) begin
      n_fail++; $display("FAIL bp_release: got vld %b rdy %b cnt %0d want 0 0010 1", bus.rsp_valid, bus.req_ready, bus.op_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    set_op(3, 32'h3F800000, 32'hFF800000);
    bus.req_valid = 4'b1000;
    bus.rsp_ready = 1'b1;
    to_drive();
    bus.req_valid = '0;
    to_drive();
    @(negedge clk);
    n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'hFF800000 || bus.rsp_overflow !== 1'b1 || bus.rsp_id !== 2'd3) begin
      n_fail++; $display("FAIL ovf_rsp: got %b %h %b %0d want 1 ff800000 1 3", bus.rsp_valid, bus.rsp_result, bus.rsp_overflow, bus.rsp_id); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    set_op(1, rnd_fp(), rnd_fp());
    set_op(2, rnd_fp(), rnd_fp());
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b1;
    to_drive();
    bus.req_valid = '0;
    to_drive();
    to_drive();
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.op_count !== 16'd1 || bus.req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL mid_pre: got cnt %0d rdy %b want 1 0010", bus.op_count, bus.req_ready); end
    to_drive();
    bus.req_valid = 4'b0110;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL mid_exec_rst: got vld %b rdy %b want 0 0000", bus.rsp_valid, bus.req_ready); end
    to_drive();
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.op_count !== 16'd0 || bus.req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL mid_exec_after: got cnt %0d rdy %b want 0 0010", bus.op_count, bus.req_ready); end
    to_drive();
    to_drive();
    @(negedge clk);
    n_chk++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_resp_pre: got vld %b want 1", bus.rsp_valid); end
    rst = 1'b1;
    #1;
    n_chk++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL mid_resp_rst: got vld %b rdy %b want 0 0000", bus.rsp_valid, bus.req_ready); end
    to_drive();
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.op_count !== 16'd0 || bus.req_ready !== 4'b0010 || bus.mul_a !== 32'h0) begin
      n_fail++; $display("FAIL mid_resp_after: got cnt %0d rdy %b mul_a %h want 0 0010 0", bus.op_count, bus.req_ready, bus.mul_a); end
  endtask

  task automatic test_random();
    logic [3:0]  v, want;
    logic [31:0] ta[4], tb_op[4];
    logic [32:0] ex;
    logic [15:0] cnt;
    int          ptr, acc, ex_id, g;
    bit          busy, want_vld;
    do_reset();
    v = '0; cnt = '0; ptr = 0; acc = 0; ex_id = 0; busy = 1'b0; ex = '0;
    for (int i = 0; i < 4; i++) begin ta[i] = '0; tb_op[i] = '0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (v[i] && $urandom_range(0, 15) == 0) v[i] = 1'b0;
        else if (!v[i] && $urandom_range(0, 2) == 0) begin v[i] = 1'b1; ta[i] = rnd_fp(); tb_op[i] = rnd_fp(); end
        set_op(i, ta[i], tb_op[i]);
      end
      bus.req_valid = v;
      bus.rsp_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      g = -1;
      if (!busy) for (int k = 0; k < 4; k++) if (g < 0 && v[(ptr + k) % 4]) g = (ptr + k) % 4;
      want = '0;
      if (g >= 0) want[g] = 1'b1;
      want_vld = busy && (cyc >= acc + 2);
      n_chk++; if (bus.req_ready !== want) begin n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", cyc, bus.req_ready, want); end
      n_chk++; if (bus.rsp_valid !== want_vld) begin n_fail++; $display("FAIL rand_vld c%0d: got %b want %b", cyc, bus.rsp_valid, want_vld); end
      n_chk++; if (bus.op_count !== cnt) begin n_fail++; $display("FAIL rand_count c%0d: got %0d want %0d", cyc, bus.op_count, cnt); end
      if (want_vld) begin
        n_chk++; if ({bus.rsp_overflow, bus.rsp_result} !== ex || bus.rsp_id !== 2'(ex_id)) begin
          n_fail++; $display("FAIL rand_rsp c%0d: got id %0d %b %h want id %0d %h", cyc, bus.rsp_id, bus.rsp_overflow, bus.rsp_result, ex_id, ex); end
      end
      if (g >= 0) begin
        busy = 1'b1; acc = cyc; ex = fmul(ta[g], tb_op[g]); ex_id = g; ptr = (g + 1) % 4; v[g] = 1'b0;
      end else if (want_vld && bus.rsp_ready) begin
        busy = 1'b0; cnt++;
      end
      to_drive();
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    test_reset();
    test_single_op();
    test_contention();
    test_fairness();
    test_backpressure();
    test_overflow();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Round-robin arbiter and sequencer that shares one combinational single-precision multiplier (`floating_point_mt`: 32-bit `a`, `b` in; `result`, `overflow` out) among `NUM_REQ` requesters. It accepts one operand pair at a time over a per-requester valid/ready handshake and registers the operands onto the multiplier inputs. It captures the product and returns it on a single response channel tagged with the requester ID, with back-pressure support. It sits between client datapaths and the multiplier instance, which is instantiated outside this block.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `ID_W`, default 2: response ID width; must equal `$clog2(NUM_REQ)`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester operand valid.
- `req_ready`  out  NUM_REQ  per-requester accept, one-hot or zero.
- `req_a`  in  32*NUM_REQ  operand A, requester i in bits [32i+31:32i].
- `req_b`  in  32*NUM_REQ  operand B, same packing as `req_a`.
- `mul_a`, `mul_b`  out  32  registered operands to the multiplier.
- `mul_result`  in  32  multiplier product, combinational from `mul_a`/`mul_b`.
- `mul_overflow`  in  1  multiplier overflow flag.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer accept.
- `rsp_result`  out  32  captured product.
- `rsp_overflow`  out  1  captured overflow flag.
- `rsp_id`  out  ID_W  index of the requester that issued the operation.
- `op_count`  out  16  completed-response counter, wraps modulo 2^16.

## Operation
- The FSM has three states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant `g` is the first index with `req_valid` set, searching from `ptr` upward modulo `NUM_REQ`.
  - `req_ready[g]=1` is combinational from `req_valid` and `ptr`. All other bits are 0, and all bits are 0 if no requester is valid.
  - On a handshake (`req_valid[g] & req_ready[g]`):
    - latch `req_a[g]` into `mul_a`, `req_b[g]` into `mul_b`, and `g` into the ID register;
    - set `ptr <= (g+1) mod NUM_REQ`;
    - go to EXEC.
- **EXEC**
  - `req_ready` is all zero.
  - `mul_a`/`mul_b` are stable for the whole cycle.
  - At the clock edge, capture `mul_result` into `rsp_result` and `mul_overflow` into `rsp_overflow`, then go to RESP.
- **RESP**
  - `rsp_valid=1`; `req_ready` is all zero.
  - When `rsp_ready=1`: `op_count <= op_count+1`, go to IDLE.
  - Otherwise hold every `rsp_*` output stable.
- `mul_a`/`mul_b` hold their last operands until the next grant. There is no re-arbitration while they are held.
- Requesters must hold `req_valid`, `req_a` and `req_b` stable until they see ready. Dropping `req_valid` before ready is legal; the request is then simply not taken.
- The block passes values through unchanged. It performs no interpretation of NaN, infinity or zero and no rounding; `rsp_result`/`rsp_overflow` are exactly what the multiplier produced.
- `ptr` advances only on a handshake. Idle cycles do not rotate priority.

## Timing
- Reset values: state=IDLE, `ptr`=0, `mul_a`=`mul_b`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_overflow`=0, `rsp_id`=0, `op_count`=0. `req_ready` follows IDLE arbitration immediately after `rst` deasserts.
- Handshake in cycle N:
  - `mul_a`/`mul_b` are valid in N+1 (EXEC);
  - `rsp_valid` rises in N+2.
- Latency from request accept to response valid is 2 cycles.
- With `rsp_ready` held at 1, the response completes in N+2 and the next grant can occur in N+3. Peak throughput is one operation per 3 cycles.
- Back-pressure stretches RESP indefinitely. No request is accepted during RESP.
- A simultaneous `rsp_ready` and new `req_valid` in RESP does not grant in that cycle; the grant is evaluated in the following IDLE cycle.
- Asserting `rst` in any state:
  - asynchronously forces state IDLE, `rsp_valid`=0 and `req_ready` all zero while `rst` is high;
  - discards any in-flight operand or response and clears `op_count` and `ptr`.
- `op_count` wraps from 0xFFFF to 0x0000 with no flag.

## Test plan
- **Single op:** requester 1 presents 0x40800000 × 0x40A00000 in cycle 0.
  - `req_ready[1]=1` in cycle 0.
  - Cycle 2: `rsp_valid=1`, `rsp_result=0x41A00000`, `rsp_overflow=0`, `rsp_id=1`.
  - `op_count=1` after `rsp_ready`.
- **Four-way contention:** all requesters valid from reset with `rsp_ready=1`.
  - Grants go to 0, 1, 2, 3, one every 3 cycles.
  - Each `rsp_id` matches its requester.
  - Operands and results: 0x42480000 × 0xC2A00000 → 0xC57A0000; 0xC1200000 × 0xC1A00000 → 0x43480000.
- **Fairness:** requesters 0 and 2 are continuously valid. The grant sequence is 0, 2, 0, 2 and `ptr` never stalls on 1 or 3.
- **Back-pressure:** hold `rsp_ready=0` for 5 cycles in RESP.
  - All `rsp_*` outputs are stable and `req_ready` is all zero throughout.
  - One cycle after `rsp_ready=1`, the next grant occurs.
- **Overflow passthrough:** 0x3F800000 × 0xFF800000 → `rsp_result=0xFF800000`, `rsp_overflow=1`.
- **Reset mid-op:** assert `rst` during EXEC and again during RESP.
  - `rsp_valid` drops without waiting for a clock edge.
  - `op_count`=0 and `ptr`=0.
  - The first grant after reset goes to the lowest valid index.
